fifo_writer_gen: RTL and testbench

Burst-mode write-side traffic generator for a standard synchronous FIFO; the producer counterpart to the periodic FIFO read-strobe logic used in the ILA test designs. While enabled, it writes bursts of BURST_LEN words carrying an incrementing data pattern, then idles GAP_CYCLES cycles before the next burst. It never issues a write while FULL is high, so the FIFO cannot overflow and the data stream observed on an ILA is gap-free and monotonic.

---
 rtl/fifo_gen_pkg.sv | 8 +
 rtl/fifo_writer_gen_gap_timer.sv | 30 +++
 rtl/fifo_writer_gen.sv | 92 +++++++++
 tb/tb_fifo_writer_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_gen_pkg.sv
// Shared types and widths for the burst-mode FIFO write generator.
package fifo_gen_pkg;

  typedef enum logic [1:0] {IDLE, BURST, GAP} wr_state_t;

  localparam int WR_COUNT_W = 16;

endpackage

// File: rtl/fifo_writer_gen_gap_timer.sv
// Loadable down-counter timing the idle gap between bursts; done marks the last gap cycle.
module gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (run && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Loaded with GAP_CYCLES-1 so the terminal count lands on the final gap cycle.
  assign done = run && (count_q == '0);

endmodule

// File: rtl/fifo_writer_gen.sv
// Burst write generator: BURST_LEN incrementing words, then GAP_CYCLES idle, never writing into a full FIFO.
// state | meaning: IDLE wait for ENABLE | BURST write pattern while !FULL | GAP count idle cycles
module fifo_writer_gen
  import fifo_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  FULL,
  output logic                  WR_EN,
  output logic [DATA_W-1:0]     DIN,
  output logic                  BUSY,
  output logic [WR_COUNT_W-1:0] WR_COUNT,
  output logic                  STALLED
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  wr_state_t               state_q, state_d;
  logic [DATA_W-1:0]       pattern_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [WR_COUNT_W-1:0]   wr_count_q;
  logic                    accept;
  logic                    last_beat;
  logic                    gap_load;
  logic                    gap_run;
  logic                    gap_done;

  // Qualified with RST so no write escapes during the reset cycle.
  assign accept    = (state_q == BURST) && !FULL && !RST;
  assign last_beat = accept && (beat_q == LAST_BEAT);

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    gap_run  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ENABLE) state_d = BURST;
      end
      BURST: begin
        if (last_beat) begin
          state_d  = GAP;
          gap_load = 1'b1;
        end
      end
      GAP: begin
        gap_run = 1'b1;
        if (gap_done) state_d = ENABLE ? BURST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      beat_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pattern_q  <= pattern_q + DATA_W'(1);
        wr_count_q <= wr_count_q + WR_COUNT_W'(1);
        beat_q     <= last_beat ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (gap_load),
    .run  (gap_run),
    .done (gap_done)
  );

  assign WR_EN    = accept;
  assign STALLED  = (state_q == BURST) && FULL && !RST;
  assign BUSY     = (state_q != IDLE);
  assign DIN      = pattern_q;
  assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_fifo_writer_gen.sv
// Self-checking bench for fifo_writer_gen: per-cycle timing checks plus a data scoreboard on every write.
module tb_fifo_writer_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENABLE = 1'b0;
  logic        FULL = 1'b0;
  logic        WR_EN;
  logic [7:0]  DIN;
  logic        BUSY;
  logic [15:0] WR_COUNT;
  logic        STALLED;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_din;

  fifo_writer_gen #(
    .DATA_W     (8),
    .BURST_LEN  (4),
    .GAP_CYCLES (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .FULL     (FULL),
    .WR_EN    (WR_EN),
    .DIN      (DIN),
    .BUSY     (BUSY),
    .WR_COUNT (WR_COUNT),
    .STALLED  (STALLED)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every observed write must match the next expected word.
  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: DIN=%0d, no write expected (t=%0t)", DIN, $time);
      end else begin
        exp_din = sb.pop_front();
        if (DIN !== exp_din) begin
          errors++;
          $display("FAIL write_data: DIN=%0d expected %0d (t=%0t)", DIN, exp_din, $time);
        end
      end
    end
  end

  // Inputs are applied just after a posedge; outputs are sampled on the following negedge.
  task automatic step(input logic en, input logic full, input logic rst);
    @(posedge CLK);
    #1;
    ENABLE = en;
    FULL   = full;
    RST    = rst;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    ENABLE = 1'b0;
    FULL = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    @(negedge CLK);
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) sb.push_back(8'((first + i) % 256));
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (WR_EN !== 1'b0 || DIN !== 8'd0 || BUSY !== 1'b0 || WR_COUNT !== 16'd0 || STALLED !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: WR_EN=%b DIN=%0d BUSY=%b WR_COUNT=%0d STALLED=%b expected all 0",
               WR_EN, DIN, BUSY, WR_COUNT, STALLED);
    end
  endtask

  task automatic test_basic_period();
    logic exp_wr;
    do_reset();
    push_range(0, 8);
    for (int c = 0; c <= 45; c++) begin
      step(c <= 24, 1'b0, 1'b0);
      exp_wr = (c >= 1 && c <= 4) || (c >= 21 && c <= 24);
      checks++;
      if (WR_EN !== exp_wr) begin
        errors++;
        $display("FAIL period_wr_en: cycle %0d WR_EN=%b expected %b", c, WR_EN, exp_wr);
      end
      if (c == 21 || c == 41) begin
        checks++;
        if (BUSY !== (c == 21)) begin
          errors++;
          $display("FAIL period_busy: cycle %0d BUSY=%b expected %b", c, BUSY, c == 21);
        end
      end
    end
    checks++;
    if (WR_COUNT !== 16'd8) begin
      errors++;
      $display("FAIL period_count: WR_COUNT=%0d expected 8", WR_COUNT);
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_range(0, 4);
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step(1'b0, (c == 2 || c == 3), 1'b0);
      checks++;
      if (c == 2 || c == 3) begin
        if (WR_EN !== 1'b0 || STALLED !== 1'b1 || DIN !== 8'd1) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d WR_EN=%b STALLED=%b DIN=%0d expected 0,1,1", c, WR_EN, STALLED, DIN);
        end
      end else if (WR_EN !== 1'b1 || STALLED !== 1'b0) begin
        errors++;
        $display("FAIL stall_write: cycle %0d WR_EN=%b STALLED=%b expected 1,0", c, WR_EN, STALLED);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (WR_COUNT !== 16'd4 || WR_EN !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL stall_after: WR_COUNT=%0d WR_EN=%b BUSY=%b expected 4,0,1", WR_COUNT, WR_EN, BUSY);
    end
  endtask

  task automatic test_enable_pulse();
    logic exp_wr;
    logic exp_busy;
    do_reset();
    push_range(0, 4);
    for (int c = 0; c <= 26; c++) begin
      step(c == 0, 1'b0, 1'b0);
      exp_wr   = (c >= 1 && c <= 4);
      exp_busy = (c >= 1 && c <= 20);
      checks++;
      if (WR_EN !== exp_wr || BUSY !== exp_busy) begin
        errors++;
        $display("FAIL pulse_timing: cycle %0d WR_EN=%b BUSY=%b expected %b,%b", c, WR_EN, BUSY, exp_wr, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_range(0, 2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (WR_EN !== 1'b0) begin
      errors++;
      $display("FAIL rst_cycle_wr_en: WR_EN=%b expected 0", WR_EN);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (WR_EN !== 1'b0 || DIN !== 8'd0 || WR_COUNT !== 16'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: WR_EN=%b DIN=%0d WR_COUNT=%0d BUSY=%b expected 0,0,0,0", WR_EN, DIN, WR_COUNT, BUSY);
    end
    push_range(0, 4);
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (WR_EN !== 1'b1) begin
        errors++;
        $display("FAIL rst_restart: beat %0d WR_EN=%b expected 1", c, WR_EN);
      end
    end
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (BUSY !== 1'b0 || WR_COUNT !== 16'd4) begin
      errors++;
      $display("FAIL rst_restart_end: BUSY=%b WR_COUNT=%0d expected 0,4", BUSY, WR_COUNT);
    end
  endtask

  task automatic test_long_full();
    int bad;
    do_reset();
    push_range(0, 4);
    bad = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b1, 1'b0);
      if (WR_EN !== 1'b0 || STALLED !== 1'b1 || DIN !== 8'd2 || BUSY !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL long_full_hold: %0d of 100 stalled cycles wrong, expected 0", bad);
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (WR_EN !== 1'b1 || STALLED !== 1'b0) begin
        errors++;
        $display("FAIL long_full_resume: beat %0d WR_EN=%b STALLED=%b expected 1,0", c, WR_EN, STALLED);
      end
    end
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (BUSY !== 1'b0 || WR_COUNT !== 16'd4) begin
      errors++;
      $display("FAIL long_full_end: BUSY=%b WR_COUNT=%0d expected 0,4", BUSY, WR_COUNT);
    end
  endtask

  task automatic test_wrap();
    int writes;
    do_reset();
    push_range(0, 256);
    writes = 0;
    for (int c = 0; c < 1300; c++) begin
      step(c <= 1264, 1'b0, 1'b0);
      if (WR_EN === 1'b1) writes++;
    end
    checks++;
    if (writes != 256 || WR_COUNT !== 16'd256) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d WR_COUNT=%0d expected 256,256", writes, WR_COUNT);
    end
    checks++;
    if (DIN !== 8'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: DIN=%0d BUSY=%b expected 0,0", DIN, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_stall();
    test_enable_pulse();
    test_reset_mid_burst();
    test_long_full();
    test_wrap();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
